// File: rtl/vram_arbiter.sv
// Frame-buffer SRAM arbiter: display scanout vs host port, one access per cycle,
// with blanking priority, host starvation guard and a 2-deep return-tag pipe.
module vram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FB_WORDS   = 307200,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              BLANK,
  input  logic              D_URGENT,
  input  logic              D_VALID,
  input  logic [ADDR_W-1:0] D_ADDR,
  output logic              D_READY,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  input  logic              H_VALID,
  input  logic              H_WE,
  input  logic [ADDR_W-1:0] H_ADDR,
  input  logic [DATA_W-1:0] H_WDATA,
  output logic              H_READY,
  output logic              H_RVALID,
  output logic [DATA_W-1:0] H_RDATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam logic [7:0]      STARVE_LIM = STARVE_MAX[7:0];
  localparam logic [ADDR_W:0] FB_LIM     = FB_WORDS[ADDR_W:0];

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 8'd1;
  endfunction

  logic [7:0]        starve_cnt;
  logic              host_wins;
  logic              d_grant;
  logic              h_grant;
  logic              grant;
  logic              sel_we;
  logic              in_range;
  logic              issue;
  logic [ADDR_W-1:0] sel_addr;

  // Return tags: p0 is aligned with the SRAM command, p1 with the SRAM read data.
  logic vld_p0, disp_p0, rng_p0;
  logic vld_p1, disp_p1, rng_p1;

  always_comb begin
    host_wins = BLANK | (~D_URGENT & (starve_cnt == STARVE_LIM));
    h_grant   = H_VALID & (~D_VALID | host_wins);
    d_grant   = D_VALID & ~h_grant;
    grant     = d_grant | h_grant;
    sel_addr  = h_grant ? H_ADDR : D_ADDR;
    sel_we    = h_grant & H_WE;
    in_range  = {1'b0, sel_addr} < FB_LIM;
    issue     = grant & in_range;
  end

  assign D_READY = d_grant;
  assign H_READY = h_grant;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      starve_cnt <= '0;
    end else if (!H_VALID || h_grant) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Stage p0: registered SRAM command; address/data hold when idle.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      vld_p0    <= 1'b0;
      disp_p0   <= 1'b0;
      rng_p0    <= 1'b0;
    end else begin
      MEM_EN  <= issue;
      MEM_WE  <= issue & sel_we;
      if (issue) begin
        MEM_ADDR <= sel_addr;
      end
      if (issue && sel_we) begin
        MEM_WDATA <= H_WDATA;
      end
      vld_p0  <= grant & ~sel_we;
      disp_p0 <= d_grant;
      rng_p0  <= in_range;
    end
  end

  // Stage p1: tag lines up with MEM_RDATA; out-of-range reads return zero.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      vld_p1  <= 1'b0;
      disp_p1 <= 1'b0;
      rng_p1  <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      disp_p1 <= disp_p0;
      rng_p1  <= rng_p0;
    end
  end

  assign D_RVALID = vld_p1 & disp_p1;
  assign H_RVALID = vld_p1 & ~disp_p1;
  assign D_RDATA  = (D_RVALID && rng_p1) ? MEM_RDATA : '0;
  assign H_RDATA  = (H_RVALID && rng_p1) ? MEM_RDATA : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level reference model with its own memory.
module tb_vram_arbiter;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 8;
  localparam int FB_WORDS   = 307200;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              nrst;
  logic              blank, d_urgent;
  logic              d_valid, d_ready, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_rdata;
  logic              h_valid, h_we, h_ready, h_rvalid;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata, h_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLK(clk), .NRST(nrst), .BLANK(blank), .D_URGENT(d_urgent),
    .D_VALID(d_valid), .D_ADDR(d_addr), .D_READY(d_ready),
    .D_RVALID(d_rvalid), .D_RDATA(d_rdata),
    .H_VALID(h_valid), .H_WE(h_we), .H_ADDR(h_addr), .H_WDATA(h_wdata),
    .H_READY(h_ready), .H_RVALID(h_rvalid), .H_RDATA(h_rdata),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'hB5;
  endfunction

  // SRAM model driven only by the DUT's memory port.
  logic [7:0] sram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[int'(mem_addr)] = mem_wdata;
      else mem_rdata = sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : init_val(int'(mem_addr));
    end
  end

  // Reference model: arbitration rules, memory contents, fixed-latency responses.
  typedef struct packed {
    logic              issue;
    logic              we;
    logic              rd;
    logic              disp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] data;
  } rec_t;

  logic [7:0] refmem [int];
  rec_t s1 = '0, s2 = '0, g;
  int   starve = 0;
  logic chk_on = 1'b0;
  logic hw, dw, d_acc = 1'b0, h_acc = 1'b0;
  int   ga;

  always @(negedge clk) begin
    if (chk_on) begin
      if (!nrst) begin
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_h_rvalid", h_rvalid, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_h_rdata", h_rdata, 0);
        s1 = '0; s2 = '0; starve = 0; d_acc = 1'b0; h_acc = 1'b0;
      end else begin
        hw = h_valid && (!d_valid || blank || (!d_urgent && starve == STARVE_MAX));
        dw = d_valid && !hw;
        chk("d_ready", d_ready, dw);
        chk("h_ready", h_ready, hw);
        chk("mem_en", mem_en, s1.issue);
        chk("mem_we", mem_we, s1.issue && s1.we);
        if (s1.issue) chk("mem_addr", mem_addr, s1.addr);
        if (s1.issue && s1.we) chk("mem_wdata", mem_wdata, s1.wdata);
        chk("d_rvalid", d_rvalid, s2.rd && s2.disp);
        chk("h_rvalid", h_rvalid, s2.rd && !s2.disp);
        if (s2.rd) chk(s2.disp ? "d_rdata" : "h_rdata", s2.disp ? d_rdata : h_rdata, s2.data);
        g = '0;
        if (hw || dw) begin
          ga = hw ? int'(h_addr) : int'(d_addr);
          g.issue = (ga < FB_WORDS);
          g.we    = hw && h_we;
          g.rd    = !g.we;
          g.disp  = dw;
          g.addr  = ADDR_W'(ga);
          g.wdata = h_wdata;
          g.data  = !g.issue ? 8'h00 : (refmem.exists(ga) ? refmem[ga] : init_val(ga));
          if (g.we && g.issue) refmem[ga] = h_wdata;
        end
        s2 = s1;
        s1 = g;
        starve = (!h_valid || hw) ? 0 : ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX);
        d_acc = dw;
        h_acc = hw;
      end
    end
  end

  function automatic logic [ADDR_W-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return ADDR_W'($urandom_range(0, 63));
    if (r < 8) return ADDR_W'($urandom_range(FB_WORDS - 10, FB_WORDS - 1));
    if (r < 9) return ADDR_W'($urandom_range(FB_WORDS, FB_WORDS + 15));
    return '1;
  endfunction

  // Both requesters valid; display re-presents a new address whenever accepted.
  task automatic contend(input int limit, output int n, output logic first_d);
    logic hr, dr;
    n = 0;
    first_d = 1'b0;
    do begin
      @(negedge clk);
      hr = h_ready;
      dr = d_ready;
      if (n == 0) first_d = dr;
      n++;
      @(posedge clk); #1;
      if (dr) d_addr = d_addr + 1'b1;
    end while (!hr && n < limit);
  endtask

  int   n, hg;
  logic fd;

  initial begin
    nrst = 1'b1; blank = 1'b0; d_urgent = 1'b0;
    d_valid = 1'b0; d_addr = '0; h_valid = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    sram[16] = 8'hA5; refmem[16] = 8'hA5;
    #1 nrst = 1'b0; chk_on = 1'b1;
    @(negedge clk);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_d_rvalid", d_rvalid, 0);

    // Solo display read, release and request on the same clock
    @(posedge clk); #1; nrst = 1'b1; d_valid = 1'b1; d_addr = 19'h00010;
    @(negedge clk); chk("t1_d_ready", d_ready, 1); chk("t1_h_ready", h_ready, 0);
    @(posedge clk); #1; d_valid = 1'b0;
    @(negedge clk);
    chk("t1_mem_en", mem_en, 1); chk("t1_mem_we", mem_we, 0); chk("t1_mem_addr", mem_addr, 19'h10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_d_rvalid", d_rvalid, 1); chk("t1_d_rdata", d_rdata, 8'hA5); chk("t1_h_rvalid", h_rvalid, 0);

    // Starvation guard
    @(posedge clk); #1; d_valid = 1'b1; d_addr = 19'd0; h_valid = 1'b1; h_we = 1'b0; h_addr = 19'h20;
    contend(30, n, fd);
    chk("t2_host_slot", n, STARVE_MAX + 1);
    h_addr = 19'h21;
    contend(30, n, fd);
    chk("t2_disp_resume", fd, 1);
    chk("t2_starve_cleared", n, STARVE_MAX + 1);

    // Urgent display blocks host; host enters as soon as urgency drops
    h_addr = 19'h22; d_urgent = 1'b1; hg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (h_ready) hg++;
      fd = d_ready;
      @(posedge clk); #1;
      if (fd) d_addr = d_addr + 1'b1;
    end
    chk("t3_no_host", hg, 0);
    d_urgent = 1'b0;
    @(negedge clk); chk("t3_host_after_urgent", h_ready, 1);

    // Host write during blanking
    @(posedge clk); #1; blank = 1'b1; h_valid = 1'b1; h_we = 1'b1; h_addr = 19'h00100; h_wdata = 8'h3C;
    @(negedge clk); chk("t4_h_ready", h_ready, 1); chk("t4_d_ready", d_ready, 0);
    @(posedge clk); #1; h_valid = 1'b0; h_we = 1'b0;
    @(negedge clk);
    chk("t4_mem_en", mem_en, 1); chk("t4_mem_we", mem_we, 1);
    chk("t4_mem_addr", mem_addr, 19'h100); chk("t4_mem_wdata", mem_wdata, 8'h3C);
    @(posedge clk); #1; d_valid = 1'b0; blank = 1'b0;
    @(negedge clk); chk("t4_no_h_rvalid", h_rvalid, 0);

    // Out-of-range host read
    @(posedge clk); #1; h_valid = 1'b1; h_addr = ADDR_W'(FB_WORDS);
    @(negedge clk); chk("t5_h_ready", h_ready, 1);
    @(posedge clk); #1; h_valid = 1'b0;
    @(negedge clk); chk("t5_mem_en", mem_en, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("t5_h_rvalid", h_rvalid, 1); chk("t5_h_rdata", h_rdata, 0);

    // Reset while a display read is in flight
    @(posedge clk); #1; d_valid = 1'b1; d_addr = 19'h30;
    @(negedge clk); chk("t6_d_ready", d_ready, 1);
    @(posedge clk); #1; d_valid = 1'b0; nrst = 1'b0;
    @(negedge clk); chk("t6_mem_en", mem_en, 0); chk("t6_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("t6_no_d_rvalid", d_rvalid, 0);
    @(posedge clk); #1; nrst = 1'b1; d_valid = 1'b1; d_addr = 19'h31;
    @(negedge clk); chk("t6_new_d_ready", d_ready, 1); chk("t6_stale_d_rvalid", d_rvalid, 0);
    @(posedge clk); #1; d_valid = 1'b0;
    @(negedge clk); chk("t6_new_mem_en", mem_en, 1); chk("t6_new_mem_addr", mem_addr, 19'h31);
    @(posedge clk); #1;
    @(negedge clk); chk("t6_new_d_rvalid", d_rvalid, 1); chk("t6_new_d_rdata", d_rdata, init_val(32'h31));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!d_valid || d_acc) begin
        d_valid = ($urandom_range(0, 3) != 0);
        d_addr  = rand_addr();
      end
      if (!h_valid || h_acc) begin
        h_valid = ($urandom_range(0, 2) != 0);
        h_we    = 1'($urandom_range(0, 1));
        h_addr  = rand_addr();
        h_wdata = 8'($urandom);
      end
      blank    = ($urandom_range(0, 7) == 0);
      d_urgent = ($urandom_range(0, 5) == 0);
    end
    @(posedge clk); #1;
    d_valid = 1'b0; h_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares the single-port synchronous frame-buffer SRAM between two requesters: display scanout (line-buffer refill) and the host/drawing port. Display normally wins. The host wins during blanking, and it is guaranteed a slot after a bounded starvation interval unless the display line buffer signals urgency. The block sits between the sync/timing generator, the line buffer and the SRAM, and issues at most one memory access per cycle, pipelined.

Parameters:
ADDR_W, 19, word address width (640x480 = 307200 words)
DATA_W, 8, pixel/word width
FB_WORDS, 307200, valid address range [0, FB_WORDS-1]
STARVE_MAX, 8, max consecutive denied host-request cycles before host is forced in (1..255)

Ports:
CLK  in  1  pixel clock
NRST  in  1  asynchronous active-low reset
BLANK  in  1  1 = outside active video (from timing generator)
D_URGENT  in  1  line buffer below low watermark; display must not be pre-empted
D_VALID  in  1  display read request
D_ADDR  in  ADDR_W  display read address
D_READY  out  1  display request accepted this cycle (combinational)
D_RVALID  out  1  display read data valid
D_RDATA  out  DATA_W  display read data
H_VALID  in  1  host request
H_WE  in  1  1 = write, 0 = read
H_ADDR  in  ADDR_W  host address
H_WDATA  in  DATA_W  host write data
H_READY  out  1  host request accepted this cycle (combinational)
H_RVALID  out  1  host read data valid
H_RDATA  out  DATA_W  host read data
MEM_EN  out  1  SRAM access enable (registered)
MEM_WE  out  1  SRAM write enable (registered)
MEM_ADDR  out  ADDR_W  SRAM address (registered)
MEM_WDATA  out  DATA_W  SRAM write data (registered)
MEM_RDATA  in  DATA_W  SRAM read data, valid the cycle after MEM_EN with MEM_WE=0

Behaviour:
- Reset (async, NRST=0): MEM_EN, MEM_WE, D_RVALID, H_RVALID = 0. MEM_ADDR, MEM_WDATA, D_RDATA, H_RDATA = 0. Starvation counter = 0. In-flight tags cleared.
- Reset mid-operation: in-flight reads are dropped and no RVALID pulse follows. A request presented at the first clock after reset release may be accepted that cycle.
- Handshake: a transfer occurs when VALID & READY at a rising edge. READY is never asserted without VALID. At most one of D_READY/H_READY is high per cycle. The requester holds its signals stable until READY.
- Grant rule, evaluated per cycle in priority order:
  - If only one requester is valid, it is granted.
  - If both are valid and BLANK=1, host wins.
  - If both are valid and D_URGENT=1, display wins.
  - If both are valid and starve_cnt == STARVE_MAX, host wins.
  - Otherwise display wins.
- Starvation counter: increments (saturating at STARVE_MAX) on each cycle with H_VALID=1 & H_READY=0. It clears to 0 on a host grant or when H_VALID=0.
- Pipeline, with the grant at edge t:
  - MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA are driven in cycle t+1.
  - For reads, MEM_RDATA is captured at edge t+2, so D_RVALID or H_RVALID is high for exactly one cycle t+2, with data.
  - Fixed read latency is 2 cycles from acceptance.
  - Back-to-back accepts give back-to-back MEM_EN and one RVALID per read, in order.
- Tag pipe: a 2-stage registered shift of {valid, is_display, in_range} routes returning data. Display and host returns never overlap because only one access is issued per cycle.
- Out-of-range (addr >= FB_WORDS):
  - The request is still accepted normally.
  - No MEM_EN is issued; MEM_WE = 0.
  - A read still returns RVALID at t+2 with RDATA = 0.
  - A write is discarded.
- Idle cycle: MEM_EN = 0, MEM_WE = 0, MEM_ADDR/MEM_WDATA hold their last value.
- Host writes produce no response pulse.
- The block does not check address width or address arithmetic; addresses pass through unchanged.

Test Plan:
- Reset then solo display read D_ADDR=0x00010, with SRAM model returning 0xA5 -> D_READY in cycle 0; MEM_EN=1, MEM_WE=0, MEM_ADDR=0x00010 in cycle 1; D_RVALID=1, D_RDATA=0xA5 in cycle 2; H_RVALID stays 0.
- BLANK=0, D_URGENT=0, D_VALID and H_VALID both held high, STARVE_MAX=8 -> display granted 8 consecutive cycles, host granted on the 9th, then display resumes; starve_cnt returns to 0.
- Same as the previous scenario but D_URGENT=1 throughout -> host never granted; starve_cnt saturates at 8. Drop D_URGENT -> host granted the next cycle.
- BLANK=1, both valid, host write H_ADDR=0x00100, H_WDATA=0x3C -> H_READY same cycle; next cycle MEM_EN=1, MEM_WE=1, MEM_ADDR=0x00100, MEM_WDATA=0x3C; no H_RVALID.
- Host read H_ADDR=307200 (out of range) -> accepted; MEM_EN stays 0; H_RVALID=1, H_RDATA=0x00 two cycles later.
- Display read accepted, NRST pulsed low in the cycle MEM_EN is high -> all outputs 0 immediately; no D_RVALID afterwards; a new request after release gets normal 2-cycle latency.
